// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encodings, register-address width, NOP encoding,
// and the pipeline-control bundle with its canonical per-situation values.
// Latency: n/a (types and constants only). Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

    // Register-file address width of the RV32 datapath
    localparam int RV_REG_ADDR_W = 5;

    // addi x0, x0, 0 -- what the datapath inserts into IF/ID on a flush
    localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

    // Controller states; encodings are shared with the datapath debug view
    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_MUL_WAIT = 2'd3
    } hz_state_t;

    // All pipeline write/flush controls for one cycle
    typedef struct packed {
        logic pc_we;
        logic pc_sel_br;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_flush;
        logic ex_mem_we;
        logic ex_mem_flush;
        logic mem_wb_we;
    } hz_ctrl_t;

    // Reset / fill: nothing advances, bubbles everywhere
    localparam hz_ctrl_t CTRL_FILL = '{pc_we: 1'b0, pc_sel_br: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1,
                                       id_ex_we: 1'b0, id_ex_flush: 1'b1, ex_mem_we: 1'b0,
                                       ex_mem_flush: 1'b1, mem_wb_we: 1'b0};

    // Normal flow: every stage advances
    localparam hz_ctrl_t CTRL_RUN = '{pc_we: 1'b1, pc_sel_br: 1'b0, if_id_we: 1'b1, if_id_flush: 1'b0,
                                      id_ex_we: 1'b1, id_ex_flush: 1'b0, ex_mem_we: 1'b1,
                                      ex_mem_flush: 1'b0, mem_wb_we: 1'b1};

    // Data memory stall: whole pipe holds, including MEM/WB
    localparam hz_ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, pc_sel_br: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                         id_ex_we: 1'b0, id_ex_flush: 1'b0, ex_mem_we: 1'b0,
                                         ex_mem_flush: 1'b0, mem_wb_we: 1'b0};

    // Multi-cycle EX op in flight: front end holds, bubbles drain into MEM behind older instructions
    localparam hz_ctrl_t CTRL_MUL_HOLD = '{pc_we: 1'b0, pc_sel_br: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                           id_ex_we: 1'b0, id_ex_flush: 1'b0, ex_mem_we: 1'b1,
                                           ex_mem_flush: 1'b1, mem_wb_we: 1'b1};

    // Taken branch in EX: redirect PC, kill the two younger instructions
    localparam hz_ctrl_t CTRL_BRANCH = '{pc_we: 1'b1, pc_sel_br: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
                                         id_ex_we: 1'b1, id_ex_flush: 1'b1, ex_mem_we: 1'b1,
                                         ex_mem_flush: 1'b0, mem_wb_we: 1'b1};

    // Load-use: hold PC and IF/ID one cycle, push a bubble into EX
    localparam hz_ctrl_t CTRL_LOAD_USE = '{pc_we: 1'b0, pc_sel_br: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                           id_ex_we: 1'b1, id_ex_flush: 1'b1, ex_mem_we: 1'b1,
                                           ex_mem_flush: 1'b0, mem_wb_we: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID (x0 never counts).
// Latency: purely combinational, same cycle.
// Backpressure: none; the flag is consumed by the hazard controller.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = RV_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_use_rs1,
    input  logic                  i_id_use_rs2,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_mem_read,
    output logic                  o_stall
);

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_rd_nonzero;

    // Only a source operand actually consumed by the ID instruction can create a dependency
    assign w_rs1_hit    = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit    = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    assign w_rd_nonzero = (i_ex_rd != '0);

    assign o_stall = i_ex_mem_read && w_rd_nonzero && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequences the 5-stage pipeline: PC write, stage-register enables and bubble flushes (optional HAZARD_PERF_CNT_EN counters).
// Latency: controls are combinational from registered state and current inputs; state updates on the next edge.
// Backpressure: i_mem_busy freezes all stages; a multi-cycle EX op holds IF/ID/EX until i_ex_mul_done.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = RV_REG_ADDR_W,
    parameter int FILL_CYCLES = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_use_rs1,
    input  logic                  i_id_use_rs2,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_mem_read,
    input  logic                  i_ex_br_taken,
    input  logic                  i_ex_mul_start,
    input  logic                  i_ex_mul_done,
    input  logic                  i_mem_busy,
    output logic                  o_pc_we,
    output logic                  o_pc_sel_br,
    output logic                  o_if_id_we,
    output logic                  o_if_id_flush,
    output logic                  o_id_ex_we,
    output logic                  o_id_ex_flush,
    output logic                  o_ex_mem_we,
    output logic                  o_ex_mem_flush,
    output logic                  o_mem_wb_we,
    output logic                  o_timeout,
    output logic [31:0]           o_stall_cnt,
    output logic [31:0]           o_flush_cnt
);

    localparam logic [7:0] FILL_INIT   = 8'(FILL_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYC);

    hz_state_t r_state;
    logic [7:0] r_cnt;
    logic       r_timeout;

    hz_state_t w_state_next;
    hz_ctrl_t   w_ctrl;
    logic [7:0] w_cnt_next;
    logic [7:0] w_cnt_inc;
    logic       w_timeout_hit;
    logic       w_load_use;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_use_rs1  (i_id_use_rs1),
        .i_id_use_rs2  (i_id_use_rs2),
        .i_ex_rd       (i_ex_rd),
        .i_ex_mem_read (i_ex_mem_read),
        .o_stall       (w_load_use)
    );

    // Wait counter saturates so a very long memory stall cannot wrap past the timeout threshold
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : (r_cnt + 8'd1);

    // Per-cycle control selection and next-state decision
    always_comb begin
        w_ctrl        = CTRL_FILL;
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            ST_MUL_WAIT: begin
                if (i_ex_mul_done) begin
                    // Result is captured this cycle; the done pulse wins over a memory stall so it is never lost
                    w_ctrl       = CTRL_RUN;
                    w_state_next = ST_RUN;
                end else begin
                    w_ctrl           = CTRL_MUL_HOLD;
                    w_ctrl.mem_wb_we = ~i_mem_busy;
                end
            end
            default: begin
                // RUN, and the MEM_WAIT cycle in which memory becomes ready (evaluated exactly as RUN)
                if (i_mem_busy) begin
                    w_ctrl = CTRL_FREEZE;
                    if (r_state == ST_MEM_WAIT) begin
                        w_cnt_next    = w_cnt_inc;
                        w_timeout_hit = (w_cnt_inc >= TIMEOUT_VAL);
                    end else begin
                        w_state_next = ST_MEM_WAIT;
                        w_cnt_next   = 8'd0;
                    end
                end else begin
                    w_ctrl       = CTRL_RUN;
                    w_state_next = ST_RUN;
                    if (i_ex_mul_start) begin
                        // EX holds the multi-cycle op, so a branch/load flag this cycle is meaningless.
                        // Done in the same cycle makes it a plain single-cycle op.
                        if (!i_ex_mul_done) begin
                            w_ctrl       = CTRL_MUL_HOLD;
                            w_state_next = ST_MUL_WAIT;
                        end
                    end else if (i_ex_br_taken) begin
                        w_ctrl = CTRL_BRANCH;
                    end else if (w_load_use) begin
                        w_ctrl = CTRL_LOAD_USE;
                    end
                end
            end
        endcase
    end

    // Controller state, wait counter and sticky timeout flag
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= ST_FILL;
            r_cnt     <= FILL_INIT;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_pc_we        = w_ctrl.pc_we;
    assign o_pc_sel_br    = w_ctrl.pc_sel_br;
    assign o_if_id_we     = w_ctrl.if_id_we;
    assign o_if_id_flush  = w_ctrl.if_id_flush;
    assign o_id_ex_we     = w_ctrl.id_ex_we;
    assign o_id_ex_flush  = w_ctrl.id_ex_flush;
    assign o_ex_mem_we    = w_ctrl.ex_mem_we;
    assign o_ex_mem_flush = w_ctrl.ex_mem_flush;
    assign o_mem_wb_we    = w_ctrl.mem_wb_we;
    // Timeout is visible in the very cycle the threshold is crossed, then held by the sticky flag
    assign o_timeout      = r_timeout | w_timeout_hit;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Stall cycles (PC held after fill) and taken-branch flush events; both wrap naturally
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if ((r_state != ST_FILL) && !w_ctrl.pc_we) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_ctrl.pc_sel_br) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`else
    assign o_stall_cnt = 32'd0;
    assign o_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic against a behavioural model.
// The model tracks "cycles since reset", "multi-cycle op outstanding" and "length of current memory stall".
// Control vector order: {pc_we, pc_sel_br, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush, mem_wb_we}.
module tb_pipeline_hazard_ctrl;

    localparam int FILL_N = 3;
    localparam int TO_N   = 8;

    localparam logic [8:0] V_FILL   = 9'b000101010;
    localparam logic [8:0] V_RUN    = 9'b101010101;
    localparam logic [8:0] V_BRANCH = 9'b111111101;
    localparam logic [8:0] V_LU     = 9'b000011101;
    localparam logic [8:0] V_FREEZE = 9'b000000000;
    localparam logic [8:0] V_MUL    = 9'b000000111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       use_rs1, use_rs2, ex_mem_read, br_taken, mul_start, mul_done, mem_busy;
    logic       o_pc_we, o_pc_sel_br, o_if_id_we, o_if_id_flush, o_id_ex_we, o_id_ex_flush;
    logic       o_ex_mem_we, o_ex_mem_flush, o_mem_wb_we, o_timeout;
    logic [31:0] o_stall_cnt, o_flush_cnt;
    logic [8:0] dut_ctrl;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int          m_since;
    bit          m_mul_pending;
    int          m_busy_run;
    bit          m_timeout;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    // Values seen at the last sample point
    logic [8:0] obs_ctrl;
    logic       obs_to;

    always #5 clk = ~clk;

    assign dut_ctrl = {o_pc_we, o_pc_sel_br, o_if_id_we, o_if_id_flush, o_id_ex_we, o_id_ex_flush,
                       o_ex_mem_we, o_ex_mem_flush, o_mem_wb_we};

    pipeline_hazard_ctrl #(
        .REG_ADDR_W  (5),
        .FILL_CYCLES (FILL_N),
        .TIMEOUT_CYC (TO_N)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_use_rs1   (use_rs1),
        .i_id_use_rs2   (use_rs2),
        .i_ex_rd        (ex_rd),
        .i_ex_mem_read  (ex_mem_read),
        .i_ex_br_taken  (br_taken),
        .i_ex_mul_start (mul_start),
        .i_ex_mul_done  (mul_done),
        .i_mem_busy     (mem_busy),
        .o_pc_we        (o_pc_we),
        .o_pc_sel_br    (o_pc_sel_br),
        .o_if_id_we     (o_if_id_we),
        .o_if_id_flush  (o_if_id_flush),
        .o_id_ex_we     (o_id_ex_we),
        .o_id_ex_flush  (o_id_ex_flush),
        .o_ex_mem_we    (o_ex_mem_we),
        .o_ex_mem_flush (o_ex_mem_flush),
        .o_mem_wb_we    (o_mem_wb_we),
        .o_timeout      (o_timeout),
        .o_stall_cnt    (o_stall_cnt),
        .o_flush_cnt    (o_flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        use_rs1 = 1'b0; use_rs2 = 1'b0; ex_mem_read = 1'b0;
        br_taken = 1'b0; mul_start = 1'b0; mul_done = 1'b0; mem_busy = 1'b0;
    endtask

    // One cycle: sample at the falling edge, compare with the model, advance the model, then move past the rising edge
    task automatic step();
        logic [8:0] exp;
        bit         lu;
        @(negedge clk);
        exp = V_FILL;
        lu  = ex_mem_read && (ex_rd != 5'd0) &&
              ((use_rs1 && (id_rs1 == ex_rd)) || (use_rs2 && (id_rs2 == ex_rd)));
        if (!rst_n) begin
            m_since = 0; m_mul_pending = 0; m_busy_run = 0; m_timeout = 0;
            m_stall = '0; m_flush = '0;
        end else if (m_since < FILL_N) begin
            exp = V_FILL;
        end else if (m_mul_pending) begin
            m_busy_run = 0;
            if (mul_done) begin
                exp = V_RUN;
                m_mul_pending = 0;
            end else begin
                exp = {V_MUL[8:1], ~mem_busy};
            end
        end else if (mem_busy) begin
            m_busy_run++;
            exp = V_FREEZE;
            if (m_busy_run > TO_N) m_timeout = 1;
        end else begin
            m_busy_run = 0;
            exp = V_RUN;
            if (mul_start) begin
                if (!mul_done) begin
                    exp = V_MUL;
                    m_mul_pending = 1;
                end
            end else if (br_taken) begin
                exp = V_BRANCH;
            end else if (lu) begin
                exp = V_LU;
            end
        end
        obs_ctrl = dut_ctrl;
        obs_to   = o_timeout;
        chk("ctrl", {23'd0, dut_ctrl}, {23'd0, exp});
        chk("timeout", {31'd0, o_timeout}, {31'd0, m_timeout});
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt", o_stall_cnt, m_stall);
        chk("flush_cnt", o_flush_cnt, m_flush);
        if (rst_n && m_since >= FILL_N && !exp[8]) m_stall = m_stall + 32'd1;
        if (rst_n && exp[7]) m_flush = m_flush + 32'd1;
`else
        chk("stall_cnt", o_stall_cnt, 32'd0);
        chk("flush_cnt", o_flush_cnt, 32'd0);
`endif
        if (rst_n && m_since < FILL_N) m_since++;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [8:0] exp);
        chk(name, {23'd0, obs_ctrl}, {23'd0, exp});
    endtask

    initial begin
        bit busy_prev;
        idle();
        rst_n = 1'b0;
        m_since = 0; m_mul_pending = 0; m_busy_run = 0; m_timeout = 0;
        m_stall = '0; m_flush = '0;
        @(posedge clk); #1;

        // Reset and fill
        step(); lit("reset_ctrl", V_FILL);
        chk("reset_timeout", {31'd0, obs_to}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < FILL_N; i++) begin
            step(); lit("fill_ctrl", V_FILL);
        end
        step(); lit("run_after_fill", V_RUN);

        // Load-use on rs2, then cleared, then x0 destination
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; use_rs2 = 1'b1;
        step(); lit("load_use", V_LU);
        ex_mem_read = 1'b0;
        step(); lit("load_use_cleared", V_RUN);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        step(); lit("load_use_x0", V_RUN);
        idle();

        // Taken branch
        br_taken = 1'b1;
        step(); lit("branch", V_BRANCH);
        br_taken = 1'b0;
        step(); lit("after_branch", V_RUN);

        // Memory stall hides a pending branch, which redirects on release
        mem_busy = 1'b1; br_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); lit("mem_freeze", V_FREEZE);
        end
        mem_busy = 1'b0;
        step(); lit("branch_on_release", V_BRANCH);
        br_taken = 1'b0;

        // Multi-cycle op: start, 5 wait cycles, done on the 6th cycle after start
        mul_start = 1'b1;
        step(); lit("mul_start", V_MUL);
        mul_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); lit("mul_wait", V_MUL);
        end
        mul_done = 1'b1;
        step(); lit("mul_done", V_RUN);
        mul_done = 1'b0;
        step(); lit("after_mul", V_RUN);

        // Timeout after 8 wait cycles beyond the first busy cycle; sticky after release
        mem_busy = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("timeout_ramp", {31'd0, obs_to}, (i >= 9) ? 32'd1 : 32'd0);
        end
        mem_busy = 1'b0;
        step(); chk("timeout_sticky", {31'd0, obs_to}, 32'd1);
        step(); chk("timeout_sticky2", {31'd0, obs_to}, 32'd1);
        rst_n = 1'b0;
        step(); chk("timeout_cleared", {31'd0, obs_to}, 32'd0);
        rst_n = 1'b1;

        // Randomized traffic
        busy_prev = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            busy_prev   = busy_prev ? ($urandom_range(0, 99) < 75) : ($urandom_range(0, 99) < 12);
            mem_busy    = busy_prev;
            mul_start   = ($urandom_range(0, 99) < 8);
            mul_done    = ($urandom_range(0, 99) < 20);
            br_taken    = ($urandom_range(0, 99) < 20);
            ex_mem_read = ($urandom_range(0, 99) < 40);
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            use_rs1     = ($urandom_range(0, 1) == 1);
            use_rs2     = ($urandom_range(0, 1) == 1);
            rst_n       = ($urandom_range(0, 599) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
